// File: rtl/mux_operand_sequencer.sv
// mux_operand_sequencer
//   Operand register bank and select sequencer feeding the 8:1 word mux.
//   Eight SIZE-bit registers drive the mux data inputs A..H. On START the
//   sequencer walks SEL from FIRST to LAST (modulo 8) and dwells DWELL
//   cycles on each entry, then pulses DONE for one cycle.
//
// Ports
//   CLK            clock, all state changes on rising edge
//   RST            synchronous active-high reset
//   WE/WADDR/WDATA operand register write port
//   START          start a sequence (IDLE only); FIRST/LAST sampled with it
//   HOLD           freeze dwell count and SEL while in RUN
//   A..H           operand registers 0..7
//   SEL            mux select
//   VALID          SEL addresses a live sequence entry
//   BUSY           sequencer in RUN
//   DONE           one-cycle pulse after the last entry's final dwell cycle
//
// state | meaning
// IDLE  | waiting for START, SEL holds its last value
// RUN   | stepping SEL through FIRST..LAST, DWELL cycles per entry

module mux_operand_sequencer #(
  parameter int SIZE  = 16,
  parameter int DWELL = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WE,
  input  logic [2:0]      WADDR,
  input  logic [SIZE-1:0] WDATA,
  input  logic            START,
  input  logic [2:0]      FIRST,
  input  logic [2:0]      LAST,
  input  logic            HOLD,
  output logic [SIZE-1:0] A,
  output logic [SIZE-1:0] B,
  output logic [SIZE-1:0] C,
  output logic [SIZE-1:0] D,
  output logic [SIZE-1:0] E,
  output logic [SIZE-1:0] F,
  output logic [SIZE-1:0] G,
  output logic [SIZE-1:0] H,
  output logic [2:0]      SEL,
  output logic            VALID,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t          state_q, state_d;
  logic [SIZE-1:0] regs_q [8];
  logic [SIZE-1:0] regs_d [8];
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      last_q, last_d;
  logic [7:0]      dwell_q, dwell_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    sel_d   = sel_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // The write port is independent of the sequencer; both may act on one edge.
    if (WE) regs_d[WADDR] = WDATA;

    unique case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (START) begin
          state_d = S_RUN;
          sel_d   = FIRST;
          last_d  = LAST;
          dwell_d = 8'd0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (!HOLD) begin
          if (dwell_q < DWELL_M1) begin
            dwell_d = dwell_q + 8'd1;
          end else if (sel_q != last_q) begin
            sel_d   = sel_q + 3'd1;   // natural 3-bit wrap 7 -> 0
            dwell_d = 8'd0;
          end else begin
            state_d = S_IDLE;
            dwell_d = 8'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      sel_q   <= 3'd0;
      last_q  <= 3'd0;
      dwell_q <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A     = regs_q[0];
  assign B     = regs_q[1];
  assign C     = regs_q[2];
  assign D     = regs_q[3];
  assign E     = regs_q[4];
  assign F     = regs_q[5];
  assign G     = regs_q[6];
  assign H     = regs_q[7];
  assign SEL   = sel_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// tb_mux_operand_sequencer
//   Directed bench for mux_operand_sequencer (SIZE=16, DWELL=10), with the
//   downstream 8:1 mux modelled locally from SEL and A..H.

module tb_mux_operand_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  WADDR = 3'd0;
  logic [15:0] WDATA = 16'd0;
  logic        START = 1'b0;
  logic [2:0]  FIRST = 3'd0;
  logic [2:0]  LAST = 3'd0;
  logic        HOLD = 1'b0;
  logic [15:0] A, B, C, D, E, F, G, H;
  logic [2:0]  SEL;
  logic        VALID, BUSY, DONE;
  logic [15:0] mux_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mux_operand_sequencer #(.SIZE(16), .DWELL(10)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .START(START), .FIRST(FIRST), .LAST(LAST), .HOLD(HOLD),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
    .SEL(SEL), .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
  );

  always_comb begin
    mux_out = 16'd0;
    case (SEL)
      3'd0: mux_out = A;
      3'd1: mux_out = B;
      3'd2: mux_out = C;
      3'd3: mux_out = D;
      3'd4: mux_out = E;
      3'd5: mux_out = F;
      3'd6: mux_out = G;
      3'd7: mux_out = H;
      default: mux_out = 16'd0;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    checks++;
    if ({SEL, VALID, BUSY, DONE} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctl sel=%0d valid=%b busy=%b done=%b expected all 0", SEL, VALID, BUSY, DONE);
    end
    checks++;
    if ({A, B, C, D, E, F, G, H} !== 128'd0) begin
      errors++;
      $display("FAIL reset_regs got %h expected 0", {A, B, C, D, E, F, G, H});
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 8; i++) begin
      WE = 1'b1; WADDR = 3'(i); WDATA = 16'(16'h0001 + i);
      tick();
    end
    WE = 1'b0;
    checks++;
    if ({A, B, C, D, E, F, G, H} !== {16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                      16'h0005, 16'h0006, 16'h0007, 16'h0008}) begin
      errors++;
      $display("FAIL load_regs got %h expected 0001..0008", {A, B, C, D, E, F, G, H});
    end
    checks++;
    if ({SEL, VALID, BUSY, DONE} !== 6'd0) begin
      errors++;
      $display("FAIL load_ctl sel=%0d valid=%b busy=%b done=%b expected all 0", SEL, VALID, BUSY, DONE);
    end
  endtask

  task automatic test_full_sweep();
    int dones = 0;
    START = 1'b1; FIRST = 3'd0; LAST = 3'd7;
    tick();
    START = 1'b0;
    for (int c = 0; c < 80; c++) begin
      checks++;
      if (SEL !== 3'(c / 10) || VALID !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
        errors++;
        $display("FAIL sweep_ctl c=%0d sel=%0d valid=%b busy=%b done=%b expected sel=%0d valid=1 busy=1 done=0",
                 c, SEL, VALID, BUSY, DONE, c / 10);
      end
      checks++;
      if (mux_out !== 16'(c / 10 + 1)) begin
        errors++;
        $display("FAIL sweep_mux c=%0d got %h expected %h", c, mux_out, 16'(c / 10 + 1));
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      if (DONE === 1'b1) dones++;
      if (k == 0) begin
        checks++;
        if (SEL !== 3'd7 || VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b1) begin
          errors++;
          $display("FAIL sweep_end sel=%0d valid=%b busy=%b done=%b expected sel=7 valid=0 busy=0 done=1",
                   SEL, VALID, BUSY, DONE);
        end
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL sweep_done_count got %0d expected 1", dones);
    end
  endtask

  task automatic test_wrap();
    START = 1'b1; FIRST = 3'd6; LAST = 3'd1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (SEL !== 3'((6 + c / 10) % 8) || BUSY !== 1'b1 || mux_out !== 16'((6 + c / 10) % 8 + 1)) begin
        errors++;
        $display("FAIL wrap_seq c=%0d sel=%0d busy=%b mux=%h expected sel=%0d busy=1",
                 c, SEL, BUSY, mux_out, (6 + c / 10) % 8);
      end
      tick();
    end
    checks++;
    if (SEL !== 3'd1 || BUSY !== 1'b0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end sel=%0d busy=%b done=%b expected sel=1 busy=0 done=1", SEL, BUSY, DONE);
    end
    tick();
  endtask

  task automatic test_single();
    START = 1'b1; FIRST = 3'd3; LAST = 3'd3;
    tick();
    START = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (SEL !== 3'd3 || BUSY !== 1'b1 || VALID !== 1'b1 || DONE !== 1'b0) begin
        errors++;
        $display("FAIL single_seq c=%0d sel=%0d busy=%b valid=%b done=%b expected sel=3 busy=1 valid=1 done=0",
                 c, SEL, BUSY, VALID, DONE);
      end
      tick();
    end
    checks++;
    if (SEL !== 3'd3 || BUSY !== 1'b0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL single_end sel=%0d busy=%b done=%b expected sel=3 busy=0 done=1", SEL, BUSY, DONE);
    end
    tick();
  endtask

  // HOLD high for the edges after samples 24..28 (SEL=2, dwell 4), with a
  // START pulse in the middle that must be ignored.
  task automatic test_hold();
    int t;
    START = 1'b1; FIRST = 3'd0; LAST = 3'd7;
    tick();
    START = 1'b0;
    for (int c = 0; c < 85; c++) begin
      t = (c <= 24) ? c : ((c <= 29) ? 24 : c - 5);
      checks++;
      if (SEL !== 3'(t / 10) || BUSY !== 1'b1 || VALID !== 1'b1) begin
        errors++;
        $display("FAIL hold_seq c=%0d sel=%0d busy=%b valid=%b expected sel=%0d busy=1 valid=1",
                 c, SEL, BUSY, VALID, t / 10);
      end
      HOLD  = (c >= 24 && c <= 28);
      START = (c == 26);
      FIRST = 3'd5; LAST = 3'd5;
      tick();
      START = 1'b0;
    end
    HOLD = 1'b0;
    checks++;
    if (SEL !== 3'd7 || BUSY !== 1'b0 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL hold_end sel=%0d busy=%b done=%b expected sel=7 busy=0 done=1", SEL, BUSY, DONE);
    end
    tick();
  endtask

  task automatic test_write_under_select();
    START = 1'b1; FIRST = 3'd4; LAST = 3'd5;
    tick();
    START = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (SEL !== 3'(4 + c / 10) || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL wsel_seq c=%0d sel=%0d busy=%b expected sel=%0d busy=1", c, SEL, BUSY, 4 + c / 10);
      end
      if (c == 4) begin
        checks++;
        if (E !== 16'hBEEF || mux_out !== 16'hBEEF) begin
          errors++;
          $display("FAIL wsel_data E=%h mux=%h expected beef", E, mux_out);
        end
      end
      WE = (c == 3); WADDR = 3'd4; WDATA = 16'hBEEF;
      tick();
      WE = 1'b0;
    end
    checks++;
    if (SEL !== 3'd5 || DONE !== 1'b1 || E !== 16'hBEEF) begin
      errors++;
      $display("FAIL wsel_end sel=%0d done=%b E=%h expected sel=5 done=1 E=beef", SEL, DONE, E);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    START = 1'b1; FIRST = 3'd1; LAST = 3'd1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done done=%b busy=%b expected done=1 busy=0", DONE, BUSY);
    end
    START = 1'b1; FIRST = 3'd2; LAST = 3'd2;
    tick();
    START = 1'b0;
    checks++;
    if (SEL !== 3'd2 || BUSY !== 1'b1 || DONE !== 1'b0 || mux_out !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_restart sel=%0d busy=%b done=%b mux=%h expected sel=2 busy=1 done=0 mux=0003",
               SEL, BUSY, DONE, mux_out);
    end
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (DONE !== 1'b1 || SEL !== 3'd2) begin
      errors++;
      $display("FAIL b2b_end done=%b sel=%0d expected done=1 sel=2", DONE, SEL);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    START = 1'b1; FIRST = 3'd0; LAST = 3'd7;
    tick();
    START = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    checks++;
    if (SEL !== 3'd5 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre sel=%0d busy=%b expected sel=5 busy=1", SEL, BUSY);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({SEL, VALID, BUSY, DONE} !== 6'd0 || {A, B, C, D, E, F, G, H} !== 128'd0) begin
      errors++;
      $display("FAIL rmid_post sel=%0d valid=%b busy=%b done=%b regs=%h expected all 0",
               SEL, VALID, BUSY, DONE, {A, B, C, D, E, F, G, H});
    end
    for (int c = 0; c < 40; c++) begin
      if (DONE === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rmid_quiet dones=%0d busy=%b expected dones=0 busy=0", dones, BUSY);
    end
    START = 1'b1; FIRST = 3'd0; LAST = 3'd1;
    tick();
    START = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (SEL !== 3'(c / 10) || BUSY !== 1'b1 || mux_out !== 16'd0) begin
        errors++;
        $display("FAIL rmid_rerun c=%0d sel=%0d busy=%b mux=%h expected sel=%0d busy=1 mux=0",
                 c, SEL, BUSY, mux_out, c / 10);
      end
      tick();
    end
    checks++;
    if (DONE !== 1'b1 || SEL !== 3'd1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rmid_rerun_end done=%b sel=%0d busy=%b expected done=1 sel=1 busy=0", DONE, SEL, BUSY);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_full_sweep();
    test_wrap();
    test_single();
    test_hold();
    test_write_under_select();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
